// File: rtl/verifier_layer_sumcheck.sv
// Verifier side of one layer's sum-check: each round checks p(0)+p(1) against the
// running claim, then folds the claim to p(tau). All arithmetic is mod 2^61-1.

module verifier_field_mul (
  input  logic        clk,
  input  logic        rstb,
  input  logic        en_i,
  input  logic [60:0] a_i,
  input  logic [60:0] b_i,
  output logic        ready_o,
  output logic [60:0] res_o
);
  localparam logic [60:0] FIELD_P = {61{1'b1}};

  logic [121:0] prod_q;
  logic         prod_vld_q;
  logic         ready_q;
  logic [60:0]  res_q;
  logic [61:0]  fold;
  logic [61:0]  fold2;
  logic [60:0]  res_d;

  // 2^61 == 1 (mod P), so the high half of the product folds onto the low half.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    fold  = {1'b0, prod_q[60:0]} + {1'b0, prod_q[121:61]};
    fold2 = {1'b0, fold[60:0]} + {61'd0, fold[61]};
    res_d = (fold2 >= {1'b0, FIELD_P}) ? (fold2[60:0] - FIELD_P) : fold2[60:0];
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      res_q      <= '0;
    end else if (en_i) begin
      prod_q     <= {61'd0, a_i} * {61'd0, b_i};
      prod_vld_q <= 1'b1;
      ready_q    <= 1'b0;
    end else if (prod_vld_q) begin
      res_q      <= res_d;
      prod_vld_q <= 1'b0;
      ready_q    <= 1'b1;
    end
  end

  assign ready_o = ready_q;
  assign res_o   = res_q;
endmodule

module verifier_layer_sumcheck #(
  parameter int nCopyBits  = 3,
  parameter int nInBits    = 3,
  parameter int lastCoeff  = (nInBits > 3) ? nInBits : 3,
  parameter int nCountBits = $clog2(nCopyBits + 2*nInBits + 2),
  localparam int F_NBITS   = 61
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic                               en,
  input  logic                               restart,
  input  logic [F_NBITS-1:0]                 claim_in,
  input  logic [(lastCoeff+1)*F_NBITS-1:0]   coeff_in,
  input  logic [F_NBITS-1:0]                 tau,
  output logic                               ready,
  output logic [nCountBits-1:0]              round,
  output logic                               cubic,
  output logic [F_NBITS-1:0]                 claim_out,
  output logic                               fail,
  output logic                               done
);
  localparam logic [F_NBITS-1:0] FIELD_P = {F_NBITS{1'b1}};
  localparam int IDX_W      = $clog2(lastCoeff + 1);
  localparam int LAST_ROUND = nCopyBits + 2*nInBits;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SUM, ST_CMP, ST_MUL_ST, ST_MUL, ST_ADD, ST_UPD
  } state_t;

  state_t                  state_q;
  logic                    en_dly_q;
  logic                    ready_q;
  logic [nCountBits-1:0]   round_q;
  logic [F_NBITS-1:0]      claim_q;
  logic                    fail_q;
  logic                    done_q;
  logic [F_NBITS-1:0]      acc_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        deg_q;
  logic [F_NBITS-1:0]      coeff_q [lastCoeff+1];
  logic [F_NBITS-1:0]      tau_q;

  logic                    start;
  logic [nCountBits-1:0]   eff_round;
  logic                    mul_en;
  logic                    mul_ready;
  logic [F_NBITS-1:0]      mul_res;

  function automatic logic [F_NBITS-1:0] fadd(input logic [F_NBITS-1:0] a,
                                              input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, FIELD_P}) ? (s[F_NBITS-1:0] - FIELD_P) : s[F_NBITS-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] degree_of(input logic [nCountBits-1:0] r);
    if (int'(r) < nCopyBits)       return IDX_W'(3);
    else if (int'(r) < LAST_ROUND) return IDX_W'(2);
    else                           return IDX_W'(nInBits);
  endfunction

  assign start     = en & ~en_dly_q;
  assign eff_round = restart ? '0 : round_q;
  assign mul_en    = (state_q == ST_MUL_ST);

  verifier_field_mul u_mul (
    .clk     (clk),
    .rstb    (rstb),
    .en_i    (mul_en),
    .a_i     (acc_q),
    .b_i     (tau_q),
    .ready_o (mul_ready),
    .res_o   (mul_res)
  );

  // NOTE: the coefficient/tau store is always written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      for (int i = 0; i <= lastCoeff; i++) coeff_q[i] <= coeff_in[i*F_NBITS +: F_NBITS];
      tau_q <= tau;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= ST_IDLE;
      en_dly_q <= 1'b1;
      ready_q  <= 1'b1;
      round_q  <= '0;
      claim_q  <= '0;
      fail_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      deg_q    <= '0;
    end else begin
      en_dly_q <= en;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SUM;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= fadd(coeff_in[F_NBITS-1:0], coeff_in[F_NBITS-1:0]);
            idx_q   <= IDX_W'(1);
            deg_q   <= degree_of(eff_round);
            round_q <= eff_round;
            if (restart) begin
              claim_q <= claim_in;
              fail_q  <= 1'b0;
            end
          end
        end
        // acc starts at 2*c[0]; adding c[1..d] gives p(0)+p(1).
        ST_SUM: begin
          acc_q <= fadd(acc_q, coeff_q[idx_q]);
          if (idx_q == deg_q) state_q <= ST_CMP;
          else                idx_q   <= idx_q + 1'b1;
        end
        ST_CMP: begin
          if (acc_q != claim_q) fail_q <= 1'b1;
          acc_q   <= coeff_q[deg_q];
          idx_q   <= deg_q - 1'b1;
          state_q <= ST_MUL_ST;
        end
        ST_MUL_ST: state_q <= ST_MUL;
        ST_MUL: begin
          if (mul_ready) state_q <= ST_ADD;
        end
        ST_ADD: begin
          acc_q <= fadd(mul_res, coeff_q[idx_q]);
          if (idx_q == '0) begin
            state_q <= ST_UPD;
          end else begin
            idx_q   <= idx_q - 1'b1;
            state_q <= ST_MUL_ST;
          end
        end
        ST_UPD: begin
          claim_q <= acc_q;
          if (int'(round_q) == LAST_ROUND) begin
            done_q  <= 1'b1;
            round_q <= '0;
          end else begin
            round_q <= round_q + 1'b1;
          end
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready     = ready_q;
  assign round     = round_q;
  assign cubic     = (int'(round_q) < nCopyBits);
  assign claim_out = claim_q;
  assign fail      = fail_q;
  assign done      = done_q;
endmodule

// File: tb/tb_verifier_layer_sumcheck.sv
// Directed bench for verifier_layer_sumcheck: a round-level model (plain modular
// arithmetic, power-sum evaluation) is compared against the DUT every idle cycle.

module tb_verifier_layer_sumcheck;
  localparam int NCOPY = 1;
  localparam int NIN   = 2;
  localparam int LMUL  = 2;
  localparam int LAST  = NCOPY + 2*NIN;
  localparam logic [60:0] P = {61{1'b1}};

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         en = 1'b1;
  logic         restart = 1'b0;
  logic [60:0]  claim_in = '0;
  logic [60:0]  tau = '0;
  logic [243:0] coeff_in = '0;
  logic         ready, cubic, fail, done;
  logic [2:0]   round;
  logic [60:0]  claim_out;

  int checks = 0;
  int failures = 0;

  // Expected architectural state after the last completed round.
  int          m_round = 0;
  logic [60:0] m_claim = '0;
  bit          m_fail = 1'b0;
  bit          m_done = 1'b0;
  bit          m_busy = 1'b0;
  bit          cmp_on = 1'b0;

  verifier_layer_sumcheck #(.nCopyBits(NCOPY), .nInBits(NIN)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .restart   (restart),
    .claim_in  (claim_in),
    .coeff_in  (coeff_in),
    .tau       (tau),
    .ready     (ready),
    .round     (round),
    .cubic     (cubic),
    .claim_out (claim_out),
    .fail      (fail),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [60:0] madd(input logic [60:0] a, input logic [60:0] b);
    logic [127:0] t;
    t = 128'(a) + 128'(b);
    return 61'(t % 128'(P));
  endfunction

  function automatic logic [60:0] mmul(input logic [60:0] a, input logic [60:0] b);
    logic [127:0] t;
    t = 128'(a) * 128'(b);
    return 61'(t % 128'(P));
  endfunction

  function automatic int degree(input int r);
    if (r < NCOPY) return 3;
    if (r < LAST)  return 2;
    return NIN;
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      check("ready", {63'd0, ready}, {63'd0, !m_busy});
      check("done", {63'd0, done}, {63'd0, m_done});
      if (!m_busy) begin
        check("round", {61'd0, round}, 64'(m_round));
        check("cubic", {63'd0, cubic}, {63'd0, (m_round < NCOPY)});
        check("claim_out", {3'd0, claim_out}, {3'd0, m_claim});
        check("fail", {63'd0, fail}, {63'd0, m_fail});
      end
    end
  end

  // One round: hold = cycle en falls, glitch = re-raise en while busy and keep it
  // high past the end, abort_at = cycle rstb is pulsed (0 = never).
  task automatic run_round(input bit rs, input logic [60:0] cin,
                           input logic [60:0] c0, input logic [60:0] c1,
                           input logic [60:0] c2, input logic [60:0] c3,
                           input logic [60:0] t, input int hold, input bit glitch,
                           input int abort_at);
    logic [60:0] c [4];
    logic [60:0] cl, s, v, pw;
    int r, d, lat;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    @(posedge clk); #1;
    restart = rs; claim_in = cin; coeff_in = {c3, c2, c1, c0}; tau = t; en = 1'b1;
    r  = rs ? 0 : m_round;
    cl = rs ? cin : m_claim;
    d  = degree(r);
    s  = c[0];
    for (int i = 0; i <= d; i++) s = madd(s, c[i]);
    v = '0; pw = 61'd1;
    for (int i = 0; i <= d; i++) begin
      v  = madd(v, mmul(c[i], pw));
      pw = mmul(pw, t);
    end
    lat = 1 + d + 1 + d*(LMUL+2) + 1;
    @(posedge clk); #1;
    m_busy = 1'b1;
    m_done = 1'b0;
    for (int k = 1; k < lat; k++) begin
      if (k == 1) begin
        coeff_in = ~coeff_in; tau = ~tau; restart = ~rs; claim_in = 61'd99;
      end
      if (k == hold) en = 1'b0;
      if (glitch && k == hold + 2) en = 1'b1;
      if (k == abort_at) begin
        rstb = 1'b0;
        m_busy = 1'b0; m_round = 0; m_claim = '0; m_fail = 1'b0; m_done = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1; en = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (rs) m_fail = 1'b0;
    if (s != cl) m_fail = 1'b1;
    m_claim = v;
    if (r == LAST) begin
      m_done = 1'b1; m_round = 0;
    end else begin
      m_round = r + 1;
    end
    m_busy = 1'b0;
    if (glitch) repeat (5) begin @(posedge clk); #1; end
    en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 cmp_on = 1'b1;
    @(posedge clk); #1;
    rstb = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("en_high_out_of_reset_ready", {63'd0, ready}, 64'd1);
    check("en_high_out_of_reset_round", {61'd0, round}, 64'd0);
    en = 1'b0;

    // Layer sequence: nCopyBits=1, nInBits=2, initial claim 11.
    run_round(1'b1, 61'd11, 61'd1, 61'd2, 61'd3, 61'd4, 61'd2, 10, 1'b0, 0);
    check("r0_claim", {3'd0, claim_out}, 64'd49);
    check("r0_round", {61'd0, round}, 64'd1);
    check("r0_cubic", {63'd0, cubic}, 64'd0);
    check("r0_fail", {63'd0, fail}, 64'd0);
    run_round(1'b0, 61'd0, 61'd10, 61'd9, 61'd20, 61'd0, 61'd3, 2, 1'b1, 0);
    check("r1_claim", {3'd0, claim_out}, 64'd217);
    run_round(1'b0, 61'd0, 61'd100, 61'd17, 61'd0, 61'd0, 61'd1, 1, 1'b0, 0);
    check("r2_claim", {3'd0, claim_out}, 64'd117);
    run_round(1'b0, 61'd0, 61'd50, 61'd17, 61'd0, 61'd0, 61'd0, 1, 1'b0, 0);
    check("r3_claim", {3'd0, claim_out}, 64'd50);
    run_round(1'b0, 61'd0, 61'd20, 61'd10, 61'd0, 61'd0, 61'd5, 1, 1'b0, 0);
    check("r4_claim", {3'd0, claim_out}, 64'd70);
    run_round(1'b0, 61'd0, 61'd30, 61'd5, 61'd5, 61'd7, 61'd2, 1, 1'b0, 0);
    check("final_claim", {3'd0, claim_out}, 64'd60);
    check("final_done", {63'd0, done}, 64'd1);
    check("final_fail", {63'd0, fail}, 64'd0);
    check("final_round", {61'd0, round}, 64'd0);

    // Non-restart start after done: back to round 0 with claim 60.
    run_round(1'b0, 61'd5, 61'd10, 61'd10, 61'd10, 61'd20, 61'd1, 1, 1'b0, 0);
    check("after_done_claim", {3'd0, claim_out}, 64'd50);
    check("after_done_done", {63'd0, done}, 64'd0);
    check("after_done_round", {61'd0, round}, 64'd1);

    // Wrap-around: p(0)+p(1) = p == 0, p(7) = 1 + 7*(p-2) = p-13.
    run_round(1'b1, 61'd0, 61'd1, 61'h1FFF_FFFF_FFFF_FFFD, 61'd0, 61'd0, 61'd7, 1, 1'b0, 0);
    check("wrap_claim", {3'd0, claim_out}, {3'd0, 61'h1FFF_FFFF_FFFF_FFF2});
    check("wrap_fail", {63'd0, fail}, 64'd0);

    // Mismatch is sticky across a matching round, cleared by restart.
    run_round(1'b1, 61'd12, 61'd1, 61'd2, 61'd3, 61'd4, 61'd2, 1, 1'b0, 0);
    check("mismatch_fail", {63'd0, fail}, 64'd1);
    check("mismatch_claim", {3'd0, claim_out}, 64'd49);
    run_round(1'b0, 61'd0, 61'd10, 61'd9, 61'd20, 61'd0, 61'd3, 1, 1'b0, 0);
    check("sticky_fail", {63'd0, fail}, 64'd1);
    check("sticky_claim", {3'd0, claim_out}, 64'd217);
    run_round(1'b1, 61'd11, 61'd1, 61'd2, 61'd3, 61'd4, 61'd2, 1, 1'b0, 0);
    check("restart_clears_fail", {63'd0, fail}, 64'd0);

    // Reset while the first multiply is in flight, then a normal restart round.
    run_round(1'b1, 61'd11, 61'd1, 61'd2, 61'd3, 61'd4, 61'd2, 1, 1'b0, 6);
    check("abort_ready", {63'd0, ready}, 64'd1);
    check("abort_claim", {3'd0, claim_out}, 64'd0);
    check("abort_round", {61'd0, round}, 64'd0);
    check("abort_fail", {63'd0, fail}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    run_round(1'b1, 61'd11, 61'd1, 61'd2, 61'd3, 61'd4, 61'd2, 1, 1'b0, 0);
    check("post_abort_claim", {3'd0, claim_out}, 64'd49);
    check("post_abort_round", {61'd0, round}, 64'd1);

    repeat (3) begin @(posedge clk); #1; end
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/verifier_layer_sumcheck.md
Name: verifier_layer_sumcheck

Overview:
- Verifier-side consumer of one layer's sum-check transcript.
- Each round it latches the round polynomial's coefficients, checks `p(0)+p(1)` equals the running claim mod p, then evaluates `p(tau)` by Horner to form the next claim.
- Round degree schedule:
  - nCopyBits cubic rounds.
  - 2*nInBits quadratic rounds.
  - One final round of degree nInBits, whose evaluation is the claim handed to the next layer's verifier.

Parameters:
- nCopyBits, 3, number of cubic (copy-variable) rounds.
- nInBits, 3, input-index bits; the final polynomial has degree nInBits.
- lastCoeff, max(3,nInBits), highest coefficient index; do not override.
- nCountBits, $clog2(nCopyBits+2*nInBits+2), round counter width; do not override.

Ports:
- clk  in  1  clock.
- rstb  in  1  reset, asynchronous, active-low.
- en  in  1  round start; the rising edge (en & ~en_dly) starts one round.
- restart  in  1  sampled at start: 1 = first round of a new layer (round 0, claim <= claim_in).
- claim_in  in  F_NBITS  initial layer claim, used only when restart is sampled.
- coeff_in  in  F_NBITS x (lastCoeff+1)  round polynomial coefficients, c[0] = constant term.
- tau  in  F_NBITS  round challenge, latched at start.
- ready  in  out  1  idle and no start pending.
- round  out  nCountBits  index of the next round to process.
- cubic  out  1  round < nCopyBits (degree of the next round is 3).
- claim_out  out  F_NBITS  current claim.
- fail  out  1  sticky: some check in this layer mismatched.
- done  out  1  the final round of the layer has completed; claim_out is the next-layer claim.

Behaviour:
- Reset values:
  - ready=1, round=0, claim_out=0, fail=0, done=0.
  - en_dly resets to 1, so en held high out of reset does not start a round.
- Start:
  - On start in ST_IDLE: latch coeff_in, tau and restart.
  - If restart: round<=0, claim<=claim_in, fail<=0, done<=0.
  - start while not idle: ignored; en must fall and rise again.
- Degree d of the current round:
  - 3 if round<nCopyBits.
  - 2 if round<nCopyBits+2*nInBits.
  - Otherwise nInBits.
  - Coefficients above d are ignored.
- All arithmetic is mod p (field_arith_defs).
  - Additions are single-cycle.
  - Multiplies use one shared field multiplier with an en/ready handshake.
- States:
  - ST_IDLE -> ST_SUM on start.
  - ST_SUM: acc=2*c[0] on entry, then adds c[1]..c[d], one per cycle, for d cycles -> ST_CMP.
  - ST_CMP, 1 cycle: if acc != claim, set fail (sticky). Set acc=c[d] -> ST_MUL_ST.
  - ST_MUL_ST / ST_MUL: issue acc*tau; wait for multiplier ready -> ST_ADD.
  - ST_ADD, 1 cycle: acc=product+c[i], i decrements from d-1. If i==0 -> ST_UPD, else -> ST_MUL_ST.
  - ST_UPD, 1 cycle: claim<=acc.
    - If this was the final round: done<=1, round<=0.
    - Else: round<=round+1.
    - Then -> ST_IDLE.
- Latency: start to ready = 1 + d + 1 + d*(Lmul+2) + 1 cycles, where Lmul is the multiplier latency.
- On fail the round still evaluates and claim still updates; fail stays set until restart or reset.
- A round start with restart=0 after done: restarts at round 0 and reuses claim_out (done cleared).
- rstb low mid-round: everything returns to reset values immediately and the in-flight multiply is discarded.
- coeff_in and tau may change after the start cycle without effect.

Test Plan:
- Setup for the layer sequence: nCopyBits=1, nInBits=2, restart=1, claim_in=11.
- Round 0: c=[1,2,3,4], tau=2 -> round 0 check passes, fail=0, claim_out=49, round=1, cubic=0.
- Rounds 1–5, continuing the same layer:
  - [10,9,20] tau=3 -> 217.
  - [100,17,0] tau=1 -> 117.
  - [50,17,0] tau=0 -> 50.
  - [20,10,0] tau=5 -> 70.
  - Final [30,5,5] tau=2 -> 60, done=1, fail=0, round=0.
- Wrap: restart, claim_in=0, c=[1,p-2,0,0], tau=7 -> no fail; claim_out=(1+7*(p-2)) mod p = p-13.
- Mismatch: restart, claim_in=12, c=[1,2,3,4], tau=2 -> fail=1, claim_out=49. The next matching round keeps fail=1; a later restart clears it.
- Handshake: en held high 10 cycles -> exactly one round; a second rising edge while busy -> ignored; ready low from the cycle after start until ST_UPD completes.
- Reset mid-round: assert rstb during ST_MUL -> ready=1, claim_out=0, round=0, fail=0, done=0; a following restart round behaves normally.
